// File: rtl/wb_arb_pkg.sv
// Shared types and defaults for the two-master Wishbone bus arbiter.
package wb_arb_pkg;

    localparam int unsigned ARB_ADDR_W  = 16;
    localparam int unsigned ARB_DATA_W  = 16;
    localparam int unsigned ARB_SEL_W   = ARB_DATA_W / 8;
    localparam int unsigned ARB_TIMEOUT = 16;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_XFER,
        ARB_RESP
    } arb_state_t;

    typedef enum logic {
        GNT_I,
        GNT_D
    } arb_grant_t;

    // Round-robin pick: on a tie the master not granted last wins.
    function automatic arb_grant_t arb_pick(input logic i_req, input logic d_req,
                                            input arb_grant_t last);
        if (i_req && d_req) begin
            return (last == GNT_D) ? GNT_I : GNT_D;
        end else if (i_req) begin
            return GNT_I;
        end else begin
            return GNT_D;
        end
    endfunction

endpackage

// File: rtl/wb_arb_timer.sv
// Transfer watchdog: counts enabled cycles and flags the TIMEOUT-th one.
module wb_arb_timer #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // cnt_q holds the number of already-completed enabled cycles, so the
    // current cycle is number cnt_q + 1; saturate once terminal is reached.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && !tc) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/wb_bus_arbiter.sv
// Two-master (fetch / load-store) Wishbone arbiter with round-robin
// tie-break, one transfer in flight, and ack-or-timeout response.
module wb_bus_arbiter
    import wb_arb_pkg::*;
#(
    parameter int unsigned ADDR_W  = ARB_ADDR_W,
    parameter int unsigned DATA_W  = ARB_DATA_W,
    parameter int unsigned SEL_W   = ARB_SEL_W,
    parameter int unsigned TIMEOUT = ARB_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    // fetch master
    input  logic              i_stb_in,
    input  logic [ADDR_W-1:0] i_adr_in,
    output logic [DATA_W-1:0] i_data_out,
    output logic              i_akn_out,
    output logic              i_err_out,
    // load/store master
    input  logic              d_stb_in,
    input  logic              d_we_in,
    input  logic [ADDR_W-1:0] d_adr_in,
    input  logic [DATA_W-1:0] d_data_in,
    input  logic [SEL_W-1:0]  d_sel_in,
    output logic [DATA_W-1:0] d_data_out,
    output logic              d_akn_out,
    output logic              d_err_out,
    // Wishbone slave side
    output logic              cyc_out,
    output logic              stb_out,
    output logic              we_out,
    output logic [ADDR_W-1:0] adr_out,
    output logic [DATA_W-1:0] data_out,
    output logic [SEL_W-1:0]  sel_out,
    input  logic [DATA_W-1:0] data_in,
    input  logic              akn_in
);

    arb_state_t        state_q, state_d;
    arb_grant_t        last_q, last_d;
    arb_grant_t        gnt_q, gnt_d;
    logic              cyc_q, cyc_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] adr_q, adr_d;
    logic [DATA_W-1:0] dat_q, dat_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic              i_akn_q, i_akn_d;
    logic              i_err_q, i_err_d;
    logic              d_akn_q, d_akn_d;
    logic              d_err_q, d_err_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              tmr_tc;

    // Timer runs only while a transfer is on the bus.
    wb_arb_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk (clk),
        .rst (rst),
        .clr (state_q != ARB_XFER),
        .en  (state_q == ARB_XFER),
        .tc  (tmr_tc)
    );

    // Next-state, grant and output-register logic.
    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        gnt_d     = gnt_q;
        cyc_d     = cyc_q;
        we_d      = we_q;
        adr_d     = adr_q;
        dat_d     = dat_q;
        sel_d     = sel_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        i_akn_d   = 1'b0;
        i_err_d   = 1'b0;
        d_akn_d   = 1'b0;
        d_err_d   = 1'b0;

        unique case (state_q)
            ARB_IDLE: begin
                if (i_stb_in || d_stb_in) begin
                    gnt_d   = arb_pick(i_stb_in, d_stb_in, last_q);
                    last_d  = gnt_d;
                    cyc_d   = 1'b1;
                    state_d = ARB_XFER;
                    if (gnt_d == GNT_I) begin
                        adr_d = i_adr_in;
                        we_d  = 1'b0;
                        sel_d = '1;
                        dat_d = '0;
                    end else begin
                        adr_d = d_adr_in;
                        we_d  = d_we_in;
                        sel_d = d_sel_in;
                        dat_d = d_data_in;
                    end
                end
            end
            ARB_XFER: begin
                // Ack is tested first so an ack on the last allowed cycle wins.
                if (akn_in) begin
                    cyc_d   = 1'b0;
                    state_d = ARB_RESP;
                    if (gnt_q == GNT_I) begin
                        i_akn_d   = 1'b1;
                        i_rdata_d = data_in;
                    end else begin
                        d_akn_d = 1'b1;
                        if (!we_q) begin
                            d_rdata_d = data_in;
                        end
                    end
                end else if (tmr_tc) begin
                    cyc_d   = 1'b0;
                    state_d = ARB_RESP;
                    if (gnt_q == GNT_I) begin
                        i_err_d = 1'b1;
                    end else begin
                        d_err_d = 1'b1;
                    end
                end
            end
            ARB_RESP: begin
                // Requests are still held here; returning to IDLE first
                // prevents granting the just-finished request a second time.
                state_d = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // State and output registers, synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ARB_IDLE;
            last_q    <= GNT_D;
            gnt_q     <= GNT_I;
            cyc_q     <= 1'b0;
            we_q      <= 1'b0;
            adr_q     <= '0;
            dat_q     <= '0;
            sel_q     <= '0;
            i_akn_q   <= 1'b0;
            i_err_q   <= 1'b0;
            d_akn_q   <= 1'b0;
            d_err_q   <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            gnt_q     <= gnt_d;
            cyc_q     <= cyc_d;
            we_q      <= we_d;
            adr_q     <= adr_d;
            dat_q     <= dat_d;
            sel_q     <= sel_d;
            i_akn_q   <= i_akn_d;
            i_err_q   <= i_err_d;
            d_akn_q   <= d_akn_d;
            d_err_q   <= d_err_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    assign cyc_out    = cyc_q;
    assign stb_out    = cyc_q;
    assign we_out     = we_q;
    assign adr_out    = adr_q;
    assign data_out   = dat_q;
    assign sel_out    = sel_q;
    assign i_akn_out  = i_akn_q;
    assign i_err_out  = i_err_q;
    assign d_akn_out  = d_akn_q;
    assign d_err_out  = d_err_q;
    assign i_data_out = i_rdata_q;
    assign d_data_out = d_rdata_q;

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Bench for wb_bus_arbiter: transaction-level reference model compared on
// every negedge, plus directed scenarios with literal expectations.
module tb_wb_bus_arbiter;

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 16;
    localparam int unsigned SW = 2;
    localparam int unsigned TO = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_stb_in = 1'b0;
    logic [AW-1:0] i_adr_in = '0;
    logic [DW-1:0] i_data_out;
    logic          i_akn_out, i_err_out;
    logic          d_stb_in = 1'b0;
    logic          d_we_in = 1'b0;
    logic [AW-1:0] d_adr_in = '0;
    logic [DW-1:0] d_data_in = '0;
    logic [SW-1:0] d_sel_in = '0;
    logic [DW-1:0] d_data_out;
    logic          d_akn_out, d_err_out;
    logic          cyc_out, stb_out, we_out;
    logic [AW-1:0] adr_out;
    logic [DW-1:0] data_out;
    logic [SW-1:0] sel_out;
    logic [DW-1:0] data_in = '0;
    logic          akn_in = 1'b0;

    int checks = 0;
    int failures = 0;

    wb_bus_arbiter #(
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .SEL_W   (SW),
        .TIMEOUT (TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_stb_in   (i_stb_in),
        .i_adr_in   (i_adr_in),
        .i_data_out (i_data_out),
        .i_akn_out  (i_akn_out),
        .i_err_out  (i_err_out),
        .d_stb_in   (d_stb_in),
        .d_we_in    (d_we_in),
        .d_adr_in   (d_adr_in),
        .d_data_in  (d_data_in),
        .d_sel_in   (d_sel_in),
        .d_data_out (d_data_out),
        .d_akn_out  (d_akn_out),
        .d_err_out  (d_err_out),
        .cyc_out    (cyc_out),
        .stb_out    (stb_out),
        .we_out     (we_out),
        .adr_out    (adr_out),
        .data_out   (data_out),
        .sel_out    (sel_out),
        .data_in    (data_in),
        .akn_in     (akn_in)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Inputs change 2 time units after a rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // ---------------- reference model (transaction level) ----------------
    bit          m_valid = 0;
    bit          m_busy = 0;      // a transfer is on the bus
    bit          m_resp = 0;      // response cycle after a finished transfer
    int          m_owner = 0;     // 0 fetch, 1 data
    bit          m_last_d = 1;
    int unsigned m_waited = 0;
    bit          m_we = 0;
    logic [AW-1:0] m_adr = '0;
    logic [SW-1:0] m_sel = '0;
    logic [DW-1:0] m_dat = '0;
    bit          m_dat_known = 1;
    logic [DW-1:0] m_i_data = '0, m_d_data = '0;
    bit          m_i_akn = 0, m_i_err = 0, m_d_akn = 0, m_d_err = 0;
    int          gnt_log[$];

    task automatic model_step();
        m_i_akn = 0; m_i_err = 0; m_d_akn = 0; m_d_err = 0;
        if (rst) begin
            m_valid = 1; m_busy = 0; m_resp = 0; m_last_d = 1; m_waited = 0;
            m_we = 0; m_adr = '0; m_sel = '0; m_dat = '0; m_dat_known = 1;
            m_i_data = '0; m_d_data = '0;
        end else if (m_resp) begin
            m_resp = 0;
        end else if (m_busy) begin
            m_waited++;
            if (akn_in) begin
                m_busy = 0; m_resp = 1;
                if (m_owner == 1) begin
                    m_d_akn = 1;
                    if (!m_we) m_d_data = data_in;
                end else begin
                    m_i_akn = 1;
                    m_i_data = data_in;
                end
            end else if (m_waited >= TO) begin
                m_busy = 0; m_resp = 1;
                if (m_owner == 1) m_d_err = 1; else m_i_err = 1;
            end
        end else if (i_stb_in || d_stb_in) begin
            if (i_stb_in && d_stb_in) m_owner = m_last_d ? 0 : 1;
            else m_owner = i_stb_in ? 0 : 1;
            m_last_d = (m_owner == 1);
            m_busy = 1; m_waited = 0;
            gnt_log.push_back(m_owner);
            if (m_owner == 1) begin
                m_adr = d_adr_in; m_we = d_we_in; m_sel = d_sel_in;
                m_dat = d_data_in; m_dat_known = 1;
            end else begin
                m_adr = i_adr_in; m_we = 0; m_sel = '1; m_dat_known = 0;
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Compare every DUT output against the model away from the active edge.
    initial forever begin
        @(negedge clk);
        if (m_valid) begin
            chk("cyc_out", 32'(cyc_out), 32'(m_busy));
            chk("stb_out", 32'(stb_out), 32'(m_busy));
            chk("we_out", 32'(we_out), 32'(m_we));
            chk("adr_out", 32'(adr_out), 32'(m_adr));
            chk("sel_out", 32'(sel_out), 32'(m_sel));
            if (m_dat_known) chk("data_out", 32'(data_out), 32'(m_dat));
            chk("i_akn_out", 32'(i_akn_out), 32'(m_i_akn));
            chk("i_err_out", 32'(i_err_out), 32'(m_i_err));
            chk("d_akn_out", 32'(d_akn_out), 32'(m_d_akn));
            chk("d_err_out", 32'(d_err_out), 32'(m_d_err));
            chk("i_data_out", 32'(i_data_out), 32'(m_i_data));
            chk("d_data_out", 32'(d_data_out), 32'(m_d_data));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    // ---------------- directed scenarios ----------------
    initial begin
        int base;

        // Reset state
        tick(); tick();
        chk("rst_cyc", 32'(cyc_out), 32'd0);
        chk("rst_adr", 32'(adr_out), 32'd0);
        chk("rst_sel", 32'(sel_out), 32'd0);
        chk("rst_idata", 32'(i_data_out), 32'd0);
        rst = 1'b0;

        // Single fetch, zero-wait slave
        i_stb_in = 1'b1; i_adr_in = 16'h0040;
        tick();
        chk("f1_cyc", 32'(cyc_out), 32'd1);
        chk("f1_adr", 32'(adr_out), 32'h0040);
        chk("f1_we", 32'(we_out), 32'd0);
        chk("f1_sel", 32'(sel_out), 32'h3);
        akn_in = 1'b1; data_in = 16'h1234;
        tick();
        chk("f1_akn", 32'(i_akn_out), 32'd1);
        chk("f1_idata", 32'(i_data_out), 32'h1234);
        chk("f1_cyc_resp", 32'(cyc_out), 32'd0);
        akn_in = 1'b0; i_stb_in = 1'b0;
        tick();
        chk("f1_akn_width", 32'(i_akn_out), 32'd0);

        // Data write, 2 wait states
        d_stb_in = 1'b1; d_we_in = 1'b1; d_adr_in = 16'h8000;
        d_data_in = 16'hBEEF; d_sel_in = 2'b01;
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk("w_cyc", 32'(cyc_out), 32'd1);
            chk("w_adr", 32'(adr_out), 32'h8000);
            chk("w_dat", 32'(data_out), 32'hBEEF);
            chk("w_sel", 32'(sel_out), 32'h1);
            chk("w_we", 32'(we_out), 32'd1);
        end
        akn_in = 1'b1; data_in = 16'hDEAD;
        tick();
        chk("w_akn", 32'(d_akn_out), 32'd1);
        chk("w_ddata_kept", 32'(d_data_out), 32'h0000);
        akn_in = 1'b0; d_stb_in = 1'b0;
        tick();
        chk("w_akn_width", 32'(d_akn_out), 32'd0);

        // Simultaneous held requests from reset: I, D, I, D every 3 cycles
        rst = 1'b1; tick(); rst = 1'b0;
        i_stb_in = 1'b1; i_adr_in = 16'h0100;
        d_stb_in = 1'b1; d_we_in = 1'b0; d_adr_in = 16'h0200; d_sel_in = 2'b11;
        akn_in = 1'b1; data_in = 16'h5A5A;
        base = gnt_log.size();
        for (int g = 0; g < 4; g++) begin
            tick();
            chk("rr_cyc", 32'(cyc_out), 32'd1);
            chk("rr_adr", 32'(adr_out), (g % 2 == 0) ? 32'h0100 : 32'h0200);
            tick();
            chk("rr_resp_cyc", 32'(cyc_out), 32'd0);
            chk("rr_akn", (g % 2 == 0) ? 32'(i_akn_out) : 32'(d_akn_out), 32'd1);
            tick();
            chk("rr_idle_cyc", 32'(cyc_out), 32'd0);
        end
        i_stb_in = 1'b0; d_stb_in = 1'b0; akn_in = 1'b0;
        chk("rr_log_n", 32'(gnt_log.size() - base), 32'd4);
        for (int g = 0; g < 4; g++) begin
            chk("rr_log", 32'(gnt_log[base + g]), 32'(g % 2));
        end
        chk("rr_ddata", 32'(d_data_out), 32'h5A5A);

        // Timeout on a data read
        d_stb_in = 1'b1; d_we_in = 1'b0; d_adr_in = 16'h0300; data_in = 16'h9999;
        for (int k = 1; k <= 16; k++) begin
            tick();
            chk("to_cyc", 32'(cyc_out), 32'd1);
        end
        tick();
        chk("to_err", 32'(d_err_out), 32'd1);
        chk("to_akn", 32'(d_akn_out), 32'd0);
        chk("to_cyc_drop", 32'(cyc_out), 32'd0);
        chk("to_ddata_kept", 32'(d_data_out), 32'h5A5A);
        d_stb_in = 1'b0;
        tick();
        chk("to_err_width", 32'(d_err_out), 32'd0);

        // Ack on the 16th XFER cycle wins over timeout
        d_stb_in = 1'b1; d_adr_in = 16'h0304;
        for (int k = 1; k <= 16; k++) begin
            tick();
            chk("late_cyc", 32'(cyc_out), 32'd1);
        end
        akn_in = 1'b1; data_in = 16'h7777;
        tick();
        chk("late_akn", 32'(d_akn_out), 32'd1);
        chk("late_err", 32'(d_err_out), 32'd0);
        chk("late_ddata", 32'(d_data_out), 32'h7777);
        akn_in = 1'b0; d_stb_in = 1'b0;
        tick();

        // Reset in the 2nd wait cycle of a fetch
        i_stb_in = 1'b1; i_adr_in = 16'h0500;
        tick(); tick(); tick();
        chk("mr_cyc_before", 32'(cyc_out), 32'd1);
        rst = 1'b1;
        tick();
        chk("mr_cyc", 32'(cyc_out), 32'd0);
        chk("mr_adr", 32'(adr_out), 32'd0);
        chk("mr_sel", 32'(sel_out), 32'd0);
        chk("mr_pulses", 32'({i_akn_out, i_err_out, d_akn_out, d_err_out}), 32'd0);
        chk("mr_idata", 32'(i_data_out), 32'd0);
        chk("mr_ddata", 32'(d_data_out), 32'd0);
        rst = 1'b0;
        i_adr_in = 16'h0600; d_stb_in = 1'b1; d_adr_in = 16'h0700; d_we_in = 1'b1;
        tick();
        chk("mr_tie_adr", 32'(adr_out), 32'h0600);
        chk("mr_tie_log", 32'(gnt_log[gnt_log.size() - 1]), 32'd0);
        akn_in = 1'b1; data_in = 16'h0A0A;
        tick();
        chk("mr_tie_akn", 32'(i_akn_out), 32'd1);
        akn_in = 1'b0; i_stb_in = 1'b0; d_stb_in = 1'b0;
        tick(); tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_bus_arbiter.md
# wb_bus_arbiter

Two-master Wishbone arbiter that shares the CPU's single 16-bit memory bus between the instruction-fetch port and the load/store port. It sits between the core and the `wishbone_if` slave side (memory model or RAM controller). It serializes requests with round-robin priority, forwards one transfer at a time, and returns ack or timeout-error to the requesting master.

## Interface
- `ADDR_W`, 16, address width
- `DATA_W`, 16, data width
- `SEL_W`, 2, byte-select width (DATA_W/8)
- `TIMEOUT`, 16, XFER cycles without `akn_in` before abort (≥2)

Clock and reset: one clock; reset is synchronous and active-high.
- `clk` in 1: clock, all logic on posedge
- `rst` in 1: synchronous, active-high reset
- `i_stb_in` in 1: fetch request
- `i_adr_in` in ADDR_W: fetch address
- `i_data_out` out DATA_W: fetched instruction
- `i_akn_out` out 1: fetch done pulse
- `i_err_out` out 1: fetch timeout pulse
- `d_stb_in` in 1: data request
- `d_we_in` in 1: 1 write, 0 read
- `d_adr_in` in ADDR_W: data address
- `d_data_in` in DATA_W: write data
- `d_sel_in` in SEL_W: byte lanes
- `d_data_out` out DATA_W: read data
- `d_akn_out` out 1: data done pulse
- `d_err_out` out 1: data timeout pulse
- `cyc_out`, `stb_out`, `we_out` out 1: Wishbone master controls
- `adr_out` out ADDR_W, `data_out` out DATA_W, `sel_out` out SEL_W: Wishbone master address/data/select
- `data_in` in DATA_W: slave read data
- `akn_in` in 1: slave ack

## Operation
- FSM states: IDLE, XFER, RESP.
- IDLE: if any `*_stb_in` is high, grant one master. Register `adr_out`, `we_out`, `data_out`, `sel_out`. Go to XFER. If neither is high, stay in IDLE.
- Fetch grant drives `we_out`=0 and `sel_out`=all ones. Data grant copies `d_we_in`, `d_sel_in` and `d_data_in`.
- Tie-break: grant the master not granted last. `last_grant` resets to D, so the first tie goes to fetch.
- XFER: `cyc_out`=`stb_out`=1, held stable.
  - On `akn_in`=1: for a read, capture `data_in` into the granted master's `*_data_out`. Go to RESP with ok.
  - On timer reaching TIMEOUT with no ack: go to RESP with error.
- RESP: `cyc_out`=`stb_out`=0. Exactly one of `*_akn_out`/`*_err_out` is high for the granted master. All requests are ignored in this state. Always go to IDLE.
- Master contract: hold `*_stb_in` and its qualifiers stable until the akn/err pulse. Drop the request, or present a new one, after the pulse.
- `*_data_out` holds its last read value. It is not updated on writes or errors.
- `akn_in` outside XFER is ignored.

## Timing
- All outputs are registered.
- Reset values:
  - state IDLE, `last_grant`=D, timer 0
  - `cyc_out`, `stb_out`, `we_out` = 0
  - `adr_out`, `data_out`, `sel_out` = 0
  - all akn/err = 0
  - `i_data_out`, `d_data_out` = 0
- Latency: request sampled in IDLE at cycle 0 → XFER in cycle 1. With a zero-wait slave (`akn_in`=1 in cycle 1), `*_akn_out`=1 in cycle 2.
- Each added slave wait state adds one cycle. Minimum 3 cycles per transfer, so back-to-back grants start every 3 cycles.
- Timer counts XFER cycles from 1. If `akn_in`=0 for TIMEOUT consecutive XFER cycles, RESP/error follows the next edge.
- `akn_in` on the TIMEOUT-th cycle counts as a success; ack wins over timeout.
- `rst` mid-XFER: next edge returns everything to reset values, with no akn/err pulse to any master.
- `akn_out`/`err_out` pulse width is exactly 1 cycle.

## Structure
- Package `wb_arb_pkg`: state enum `arb_state_t` {ARB_IDLE, ARB_XFER, ARB_RESP}, grant enum `arb_grant_t` {GNT_I, GNT_D}, default width localparams.
- Sub-module `wb_arb_timer`: clear/enable counter with a terminal-count output at TIMEOUT.
- Top-level holds the FSM, grant register and output registers.

## Test plan
- Single fetch, zero-wait slave: `i_adr_in`=0x0040 and `data_in`=0x1234 with `akn_in` in cycle 1. Expect `adr_out`=0x0040, `we_out`=0; cycle 2 `i_akn_out`=1, `i_data_out`=0x1234.
- Data write, 2 wait states: `d_adr_in`=0x8000, `d_data_in`=0xBEEF, `d_sel_in`=2'b01. Expect bus fields match for 3 XFER cycles, then `d_akn_out` for 1 cycle; `d_data_out` unchanged.
- Simultaneous requests from reset, both held: grants alternate I, D, I, D. Each transfer takes 3 cycles with no stale re-grant in RESP.
- Timeout: slave never acks a `d_stb_in` read. `cyc_out` is high for 16 cycles, then `d_err_out`=1 for 1 cycle, and `d_data_out` retains its old value.
- Ack on the 16th XFER cycle: `d_akn_out` fires and `d_err_out` stays 0.
- Reset mid-XFER: assert `rst` in the 2nd wait cycle. Next cycle all outputs are 0 and no akn/err fires; the next tie goes to fetch.
